// File: rtl/frame_check_fsm_pkg.sv
// Shared types for the Rx frame-alignment controller.
package frame_check_fsm_pkg;

  localparam int unsigned FRAME_POS_W = 5;

  // Position of the beat presented alongside unscrambled_data: header, 25 body beats, tail.
  typedef enum logic [FRAME_POS_W-1:0] {
    IDLEB     = 5'd0,
    DATA1     = 5'd1,
    DATA2     = 5'd2,
    DATA3     = 5'd3,
    DATA4     = 5'd4,
    DATA5     = 5'd5,
    DATA6     = 5'd6,
    DATA7     = 5'd7,
    DATA8     = 5'd8,
    DATA9     = 5'd9,
    DATA10    = 5'd10,
    DATA11    = 5'd11,
    DATA12    = 5'd12,
    DATA13    = 5'd13,
    DATA14    = 5'd14,
    DATA15    = 5'd15,
    DATA16    = 5'd16,
    DATA17    = 5'd17,
    DATA18    = 5'd18,
    DATA19    = 5'd19,
    DATA20    = 5'd20,
    DATA21    = 5'd21,
    DATA22    = 5'd22,
    DATA23    = 5'd23,
    DATA24    = 5'd24,
    DATA25    = 5'd25,
    DATA_TAIL = 5'd26
  } frame_state_t;

endpackage

// File: rtl/frame_check_fsm.sv
// Frame-header search, lock hysteresis and frame-position sequencing for the Rx decode path.
// The saturating header-error counter is built only when FRAME_HDR_ERR_CNT_EN is defined.
module frame_check_fsm
  import frame_check_fsm_pkg::*;
#(
  parameter logic [29:0] SYNC_PATTERN = 30'h2A3C_5F0E,
  parameter int unsigned LOCK_CNT     = 3,
  parameter int unsigned UNLOCK_CNT   = 4,
  parameter int unsigned ERR_CNT_W    = 16
) (
  input  logic                 clk_390p625M,
  input  logic                 rst_n,
  input  logic [61:0]          rx_data,
  output frame_state_t         frame_state,
  output logic                 data_tail_flag,
  output logic                 dly_data_tail_flag,
  output logic                 frame_lock,
  output logic [ERR_CNT_W-1:0] hdr_err_cnt,
  input  logic                 clr_err_cnt
);

  localparam int unsigned POS_W    = FRAME_POS_W;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LAST_POS = 26;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  sync_state_t        sync_q, sync_d;
  logic [POS_W-1:0]   pos_q, pos_d, pos_next;
  logic [CNT_W-1:0]   good_q, good_d, good_inc;
  logic [CNT_W-1:0]   bad_q, bad_d, bad_inc;
  logic               emit_q, emit_d;
  frame_state_t       frame_state_q, frame_state_d;
  logic               tail_q, tail_d;
  logic               dly_tail_q;
  logic               lock_q, lock_d;
  logic               hdr_ok;
  logic               at_hdr;
  logic               err_inc;

  assign hdr_ok   = (rx_data[61:32] == SYNC_PATTERN);
  assign at_hdr   = (pos_q == '0);
  assign pos_next = (pos_q == POS_W'(LAST_POS)) ? '0 : pos_q + POS_W'(1);
  assign good_inc = good_q + CNT_W'(1);
  assign bad_inc  = bad_q + CNT_W'(1);

  // Next-state: sync FSM, free-running position, and the per-frame emit decision taken at the header.
  always_comb begin
    sync_d        = sync_q;
    pos_d         = pos_q;
    good_d        = good_q;
    bad_d         = bad_q;
    emit_d        = emit_q;
    err_inc       = 1'b0;
    frame_state_d = IDLEB;

    if ((sync_q != HUNT) && !at_hdr && emit_q) begin
      frame_state_d = frame_state_t'(pos_q);
    end

    unique case (sync_q)
      HUNT: begin
        pos_d  = '0;
        emit_d = 1'b0;
        if (hdr_ok) begin
          pos_d  = POS_W'(1);
          good_d = CNT_W'(1);
          bad_d  = '0;
          sync_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
      end

      VERIFY: begin
        pos_d = pos_next;
        if (at_hdr) begin
          if (hdr_ok) begin
            good_d = good_inc;
            if (good_inc == CNT_W'(LOCK_CNT)) begin
              sync_d = LOCKED;
              bad_d  = '0;
            end
          end else begin
            sync_d = HUNT;
            good_d = '0;
            pos_d  = '0;
          end
        end
      end

      LOCKED: begin
        pos_d = pos_next;
        if (at_hdr) begin
          emit_d = 1'b1;
          if (hdr_ok) begin
            bad_d = '0;
          end else begin
            bad_d   = bad_inc;
            err_inc = 1'b1;
            // Unlock only at a header so the previous frame has already been released whole.
            if (bad_inc == CNT_W'(UNLOCK_CNT)) begin
              sync_d = HUNT;
              bad_d  = '0;
              good_d = '0;
              pos_d  = '0;
              emit_d = 1'b0;
            end
          end
        end
      end

      default: begin
        sync_d = HUNT;
        pos_d  = '0;
        good_d = '0;
        bad_d  = '0;
        emit_d = 1'b0;
      end
    endcase

    tail_d = (frame_state_d == DATA_TAIL);
    lock_d = (sync_d == LOCKED);
  end

  always_ff @(posedge clk_390p625M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= HUNT;
      pos_q         <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      emit_q        <= 1'b0;
      frame_state_q <= IDLEB;
      tail_q        <= 1'b0;
      dly_tail_q    <= 1'b0;
      lock_q        <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      pos_q         <= pos_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      emit_q        <= emit_d;
      frame_state_q <= frame_state_d;
      tail_q        <= tail_d;
      dly_tail_q    <= tail_q;
      lock_q        <= lock_d;
    end
  end

  assign frame_state        = frame_state_q;
  assign data_tail_flag     = tail_q;
  assign dly_data_tail_flag = dly_tail_q;
  assign frame_lock         = lock_q;

`ifdef FRAME_HDR_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 unused_bits;

  // Clear has priority over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err_cnt) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_390p625M or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign hdr_err_cnt = err_cnt_q;
  assign unused_bits = ^rx_data[31:0];
`else
  logic unused_bits;

  assign hdr_err_cnt = '0;
  assign unused_bits = ^{rx_data[31:0], clr_err_cnt, err_inc};
`endif

endmodule
